// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational 32-bit ALU
// between two requesters. The winning operands are registered and drive the
// ALU. The result and flags are captured in a response buffer, and that buffer
// is returned to the winner over a valid/ready handshake.
// Sequence per operation: IDLE (accept) -> EXEC (ALU evaluates) -> HOLD (respond).
module alu_arbiter #(
    parameter int   TAG_W      = 4,
    parameter logic RESET_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic [4:0]       rsp0_flags,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic [4:0]       rsp1_flags,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             rsp1_err,

    output logic [31:0]      alu_src_a,
    output logic [31:0]      alu_src_b,
    output logic [3:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic [4:0]       alu_zero_flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_LAST_LEG = 4'b1010;

    logic [1:0]       state_q,       state_d;
    logic             last_grant_q,  last_grant_d;
    logic             owner_q,       owner_d;
    logic [31:0]      alu_src_a_q,   alu_src_a_d;
    logic [31:0]      alu_src_b_q,   alu_src_b_d;
    logic [3:0]       alu_control_q, alu_control_d;
    logic [TAG_W-1:0] req_tag_q,     req_tag_d;
    logic [31:0]      rsp_result_q,  rsp_result_d;
    logic [4:0]       rsp_flags_q,   rsp_flags_d;
    logic [TAG_W-1:0] rsp_tag_q,     rsp_tag_d;
    logic             rsp_err_q,     rsp_err_d;

    logic             grant_sel;
    logic             owner_ready;

    // Round-robin pick. A lone valid requester wins. On a tie, the requester
    // that did not win last time is chosen.
    always_comb begin
        grant_sel  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == ST_IDLE) && req0_valid && !grant_sel;
        req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant_sel;
    end

    // Response side: only the owner sees valid. Both ports show the buffer.
    always_comb begin
        rsp0_valid  = (state_q == ST_HOLD) && !owner_q;
        rsp1_valid  = (state_q == ST_HOLD) &&  owner_q;
        owner_ready = owner_q ? rsp1_ready : rsp0_ready;
        rsp0_result = rsp_result_q;
        rsp1_result = rsp_result_q;
        rsp0_flags  = rsp_flags_q;
        rsp1_flags  = rsp_flags_q;
        rsp0_tag    = rsp_tag_q;
        rsp1_tag    = rsp_tag_q;
        rsp0_err    = rsp_err_q;
        rsp1_err    = rsp_err_q;
        alu_src_a   = alu_src_a_q;
        alu_src_b   = alu_src_b_q;
        alu_control = alu_control_q;
    end

    // Next-state and datapath update for the IDLE/EXEC/HOLD sequence.
    always_comb begin
        // NOTE: every _d starts from its _q so that no path leaves a variable
        // unassigned; an unassigned path would infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        alu_src_a_d   = alu_src_a_q;
        alu_src_b_d   = alu_src_b_q;
        alu_control_d = alu_control_q;
        req_tag_d     = req_tag_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    alu_src_a_d   = grant_sel ? req1_a   : req0_a;
                    alu_src_b_d   = grant_sel ? req1_b   : req0_b;
                    alu_control_d = grant_sel ? req1_op  : req0_op;
                    req_tag_d     = grant_sel ? req1_tag : req0_tag;
                    owner_d       = grant_sel;
                    last_grant_d  = grant_sel;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Codes beyond the last legal op return a clean zero with err set.
                if (alu_control_q > OP_LAST_LEG) begin
                    rsp_result_d = '0;
                    rsp_flags_d  = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_zero_flags;
                    rsp_err_d    = 1'b0;
                end
                rsp_tag_d = req_tag_q;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples its _d value from before the edge.
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= RESET_LAST;
            owner_q       <= 1'b0;
            alu_src_a_q   <= '0;
            alu_src_b_q   <= '0;
            alu_control_q <= OP_ADD;
            req_tag_q     <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            alu_control_q <= alu_control_d;
            req_tag_q     <= req_tag_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter. A small ALU stub closes the
// alu_* loop. Inputs are driven and outputs sampled around the falling edge.
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    // Op encoding used by the ALU stub. The arbiter itself knows only ADD
    // (its reset op) and that codes above 4'b1010 are illegal.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_op, req1_op;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [4:0]       rsp0_flags, rsp1_flags;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
    logic             rsp0_err, rsp1_err;
    logic [31:0]      alu_src_a, alu_src_b, alu_result;
    logic [3:0]       alu_control;
    logic [4:0]       alu_zero_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(TAG_W), .RESET_LAST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags), .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags), .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero_flags(alu_zero_flags)
    );

    // ALU stub. Flags are {zero, lt_signed, lt_unsigned, sign, overflow}.
    // The compare flags are raised only by the compare ops. For SLTU, sign
    // carries the MSB of a-b. Illegal codes return junk, which the arbiter
    // must mask.
    always_comb begin
        logic [31:0] diff;
        diff           = alu_src_a - alu_src_b;
        alu_result     = 32'hDEADBEEF;
        alu_zero_flags = 5'b11111;
        case (alu_control)
            OP_AND:  alu_result = alu_src_a & alu_src_b;
            OP_OR:   alu_result = alu_src_a | alu_src_b;
            OP_XOR:  alu_result = alu_src_a ^ alu_src_b;
            OP_ADD:  alu_result = alu_src_a + alu_src_b;
            OP_SUB:  alu_result = diff;
            OP_SLT:  alu_result = {31'd0, $signed(alu_src_a) < $signed(alu_src_b)};
            OP_SLTU: alu_result = {31'd0, alu_src_a < alu_src_b};
            default: alu_result = 32'hDEADBEEF;
        endcase
        if (alu_control <= OP_SLTU) begin
            alu_zero_flags = {alu_result == 32'd0,
                              (alu_control == OP_SLT)  && ($signed(alu_src_a) < $signed(alu_src_b)),
                              (alu_control == OP_SLTU) && (alu_src_a < alu_src_b),
                              (alu_control == OP_SLTU) && diff[31],
                              1'b0};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [TAG_W-1:0] tag);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = tag;
    endtask

    task automatic drive_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [TAG_W-1:0] tag);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = tag;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive_req0(1'b0, '0, '0, '0, '0);
        drive_req1(1'b0, '0, '0, '0, '0);
        step();

        // Reset values
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_alu_control", alu_control, 4'b0011);
        check("rst_alu_src_a", alu_src_a, 0);
        check("rst_alu_src_b", alu_src_b, 0);
        check("rst_rsp_result", rsp0_result, 0);
        check("rst_rsp_flags", rsp1_flags, 0);
        check("rst_rsp_tag", rsp0_tag, 0);
        check("rst_rsp_err", rsp1_err, 0);
        rst_n = 1'b1;
        step();

        // 1. Single request: ADD 5+7, tag 3
        drive_req0(1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        step();                      // EXEC
        drive_req0(1'b0, '0, '0, '0, '0);
        check("t1_exec_rsp0_valid", rsp0_valid, 0);
        check("t1_exec_src_a", alu_src_a, 32'd5);
        check("t1_exec_src_b", alu_src_b, 32'd7);
        check("t1_exec_ctrl", alu_control, OP_ADD);
        step();                      // HOLD (T+2)
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp1_valid", rsp1_valid, 0);
        check("t1_result", rsp0_result, 32'd12);
        check("t1_flags", rsp0_flags, 5'b00000);
        check("t1_tag", rsp0_tag, 4'd3);
        check("t1_err", rsp0_err, 0);
        rsp0_ready = 1'b1;
        step();                      // IDLE
        rsp0_ready = 1'b0;
        check("t1_rsp0_drop", rsp0_valid, 0);

        // 2. Tie after reset goes to req0
        pulse_reset();
        drive_req0(1'b1, 32'd3, 32'd3, OP_SUB, 4'd1);
        drive_req1(1'b1, 32'd1, 32'd2, OP_SLTU, 4'd2);
        #1;
        check("t2_tie_req0_ready", req0_ready, 1);
        check("t2_tie_req1_ready", req1_ready, 0);
        step();                      // EXEC
        drive_req0(1'b0, '0, '0, '0, '0);
        check("t2_exec_req1_ready", req1_ready, 0);
        step();                      // HOLD
        check("t2_rsp0_valid", rsp0_valid, 1);
        check("t2_rsp1_valid", rsp1_valid, 0);
        check("t2_sub_result", rsp0_result, 32'd0);
        check("t2_sub_flags", rsp0_flags, 5'b10000);
        check("t2_sub_tag", rsp0_tag, 4'd1);
        check("t2_hold_req1_ready", req1_ready, 0);
        rsp0_ready = 1'b1;
        step();                      // IDLE, req1 granted
        rsp0_ready = 1'b0;
        check("t2_rsp0_drop", rsp0_valid, 0);
        check("t2_req1_ready", req1_ready, 1);
        step();                      // EXEC
        drive_req1(1'b0, '0, '0, '0, '0);
        step();                      // HOLD
        check("t2_rsp1_valid", rsp1_valid, 1);
        check("t2_rsp0_valid_off", rsp0_valid, 0);
        check("t2_sltu_result", rsp1_result, 32'd1);
        check("t2_sltu_flags", rsp1_flags, 5'b00110);
        check("t2_sltu_tag", rsp1_tag, 4'd2);

        // 3. Backpressure on rsp1 while both requesters wait
        drive_req0(1'b1, 32'd10, 32'd20, OP_ADD, 4'd5);
        drive_req1(1'b1, 32'hFFFFFFFF, 32'd0, 4'b1111, 4'hF);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3_bp_valid_%0d", i), rsp1_valid, 1);
            check($sformatf("t3_bp_result_%0d", i), rsp1_result, 32'd1);
            check($sformatf("t3_bp_tag_%0d", i), rsp1_tag, 4'd2);
            check($sformatf("t3_bp_req0_ready_%0d", i), req0_ready, 0);
        end
        rsp1_ready = 1'b1;
        step();                      // IDLE: second tie goes to req0
        rsp1_ready = 1'b0;
        check("t3_rsp1_drop", rsp1_valid, 0);
        check("t3_tie2_req0_ready", req0_ready, 1);
        check("t3_tie2_req1_ready", req1_ready, 0);
        step();                      // EXEC
        drive_req0(1'b0, '0, '0, '0, '0);
        step();                      // HOLD
        check("t3_add_valid", rsp0_valid, 1);
        check("t3_add_result", rsp0_result, 32'd30);
        check("t3_add_tag", rsp0_tag, 4'd5);
        rsp0_ready = 1'b1;
        step();                      // IDLE, req1 (illegal op) granted
        rsp0_ready = 1'b0;
        check("t4_req1_ready", req1_ready, 1);

        // 4. Illegal op on req1
        step();                      // EXEC
        drive_req1(1'b0, '0, '0, '0, '0);
        check("t4_exec_ctrl", alu_control, 4'b1111);
        step();                      // HOLD
        check("t4_rsp1_valid", rsp1_valid, 1);
        check("t4_err", rsp1_err, 1);
        check("t4_result", rsp1_result, 32'd0);
        check("t4_flags", rsp1_flags, 5'b00000);
        check("t4_tag", rsp1_tag, 4'hF);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;

        // 5. Signed compare, legal op right after the illegal one
        drive_req0(1'b1, 32'h80000000, 32'd1, OP_SLT, 4'd9);
        #1;
        check("t5_req0_ready", req0_ready, 1);
        step();
        drive_req0(1'b0, '0, '0, '0, '0);
        step();
        check("t5_rsp0_valid", rsp0_valid, 1);
        check("t5_result", rsp0_result, 32'd1);
        check("t5_flags", rsp0_flags, 5'b01000);
        check("t5_err", rsp0_err, 0);
        check("t5_tag", rsp0_tag, 4'd9);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        step();
        step();
        check("t5_idle_src_a_held", alu_src_a, 32'h80000000);
        check("t5_idle_ctrl_held", alu_control, OP_SLT);

        // 6. Reset during EXEC
        drive_req0(1'b1, 32'd1, 32'd1, OP_ADD, 4'd7);
        step();                      // EXEC
        drive_req0(1'b0, '0, '0, '0, '0);
        check("t6_in_exec_ctrl", alu_control, OP_ADD);
        check("t6_in_exec_src_a", alu_src_a, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp0_valid", rsp0_valid, 0);
        check("t6_rst_rsp1_valid", rsp1_valid, 0);
        check("t6_rst_req0_ready", req0_ready, 0);
        check("t6_rst_src_a", alu_src_a, 0);
        check("t6_rst_tag", rsp0_tag, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_no_rsp0_%0d", i), rsp0_valid, 0);
        end
        drive_req0(1'b1, 32'd2, 32'd2, OP_ADD, 4'd4);
        drive_req1(1'b1, 32'd2, 32'd2, OP_ADD, 4'd6);
        #1;
        check("t6_tie_req0_ready", req0_ready, 1);
        check("t6_tie_req1_ready", req1_ready, 0);
        step();
        drive_req0(1'b0, '0, '0, '0, '0);
        drive_req1(1'b0, '0, '0, '0, '0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no end, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
